seg7_rx_checker: RTL

//  Receive side of the 7-segment display bus driven by our letter-cycling FSMs (A..F on seg[7:0]).

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 14 +
 rtl/seg7_rx_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive checker: active-low code table,
// tracking states and the byte-to-hex decode function.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;
  localparam int unsigned HEX_W = 4;
  localparam int unsigned NUM_CODES = 16;

  // Active-low segment codes for hex digits 0..F; bit7 is DP and stays high.
  localparam logic [SEG_W-1:0] SEG7_CODES [NUM_CODES] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } seg7_state_t;

  // Returns {ok, hex}; ok=0 and hex=0 for any byte outside the table.
  function automatic logic [HEX_W:0] seg7_to_hex(input logic [SEG_W-1:0] seg);
    logic [HEX_W:0] res;
    res = '0;
    for (int i = 0; i < int'(NUM_CODES); i++) begin
      if (seg == SEG7_CODES[i]) begin
        res = {1'b1, HEX_W'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational lookup of an active-low segment byte back to its hex digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             ok_c,
  output logic [HEX_W-1:0] hex_c
);

  always_comb begin
    {ok_c, hex_c} = seg7_to_hex(seg_i);
  end

endmodule

// File: rtl/seg7_rx_checker.sv
// Receive-side checker for the letter-cycling 7-segment bus: decodes samples,
// tracks the cyclic FIRST..LAST sequence, reports lock and counts breaks.
module seg7_rx_checker
  import seg7_pkg::*;
#(
  parameter int unsigned     LOCK_N = 6,
  parameter int unsigned     ERR_W  = 8,
  parameter logic [HEX_W-1:0] FIRST = 4'hA,
  parameter logic [HEX_W-1:0] LAST  = 4'hF
) (
  input  logic             ck,
  input  logic             rs,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             seg_vld,
  output logic [HEX_W-1:0] digit,
  output logic             digit_vld,
  output logic             bad_code,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned      RUN_W   = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  seg7_state_t      state_q;
  logic [RUN_W-1:0] run_q;
  logic [HEX_W-1:0] exp_q;
  logic [HEX_W-1:0] digit_q;
  logic             digit_vld_q;
  logic             bad_code_q;
  logic             locked_q;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             dec_ok_c;
  logic [HEX_W-1:0] dec_hex_c;
  logic             in_range_c;
  logic             match_c;
  logic [HEX_W-1:0] exp_d;
  logic [RUN_W-1:0] run_d;
  logic [ERR_W-1:0] err_cnt_d;

  seg7_decode u_decode (
    .seg_i (seg_in),
    .ok_c  (dec_ok_c),
    .hex_c (dec_hex_c)
  );

  // Sample classification and saturating next values for run and error count.
  always_comb begin
    in_range_c = dec_ok_c && (dec_hex_c >= FIRST) && (dec_hex_c <= LAST);
    match_c    = dec_ok_c && (dec_hex_c == exp_q);
    exp_d      = (dec_hex_c == LAST) ? FIRST : dec_hex_c + HEX_W'(1);
    run_d      = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    err_cnt_d  = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge ck) begin
    if (!rs) begin
      state_q     <= HUNT;
      run_q       <= '0;
      exp_q       <= FIRST;
      digit_q     <= '0;
      digit_vld_q <= 1'b0;
      bad_code_q  <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      digit_vld_q <= 1'b0;
      bad_code_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      if (seg_vld) begin
        if (dec_ok_c) begin
          digit_q     <= dec_hex_c;
          digit_vld_q <= 1'b1;
        end else begin
          bad_code_q <= 1'b1;
        end
        unique case (state_q)
          HUNT: begin
            if (in_range_c) begin
              state_q <= TRACK;
              run_q   <= RUN_W'(1);
              exp_q   <= exp_d;
            end
          end
          TRACK: begin
            if (match_c) begin
              run_q <= run_d;
              exp_q <= exp_d;
              if (run_d == RUN_MAX) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (in_range_c) begin
              // Out-of-order but plausible digit: restart the run from it.
              run_q <= RUN_W'(1);
              exp_q <= exp_d;
            end else begin
              state_q <= HUNT;
              run_q   <= '0;
            end
          end
          LOCKED: begin
            if (match_c) begin
              exp_q <= exp_d;
            end else begin
              // The failing sample is discarded rather than used as a new seed.
              seq_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              locked_q  <= 1'b0;
              state_q   <= HUNT;
              run_q     <= '0;
            end
          end
          default: begin
            state_q <= HUNT;
            run_q   <= '0;
          end
        endcase
      end
    end
  end

  assign digit     = digit_q;
  assign digit_vld = digit_vld_q;
  assign bad_code  = bad_code_q;
  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
